// File: rtl/fp_wb_arbiter.sv
// Round-robin writeback arbiter: picks one FP unit result per cycle, acks it,
// and registers it into a single output stage with a valid/ready handshake.
module fp_wb_arbiter #(
   parameter int NUM_UNITS = 3,
   parameter int DATA_W    = 34,
   parameter int ID_W      = 3,
   localparam int IDX_W    = $clog2(NUM_UNITS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_UNITS-1:0]        unit_done,
   input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
   input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
   output logic [NUM_UNITS-1:0]        unit_ack,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [ID_W-1:0]             wb_id,
   output logic [DATA_W-1:0]           wb_rd,
   output logic [IDX_W-1:0]            wb_unit
);

   logic [IDX_W-1:0]     rr_ptr_r;
   logic [NUM_UNITS-1:0] grant_s;
   logic [IDX_W-1:0]     win_idx_s;
   logic [ID_W-1:0]      win_id_s;
   logic [DATA_W-1:0]    win_rd_s;
   logic                 any_grant_s;
   logic                 load_s;

   // Output slot is free, or it drains this cycle and can take a new result.
   assign load_s      = !wb_valid || wb_ready;
   assign any_grant_s = |grant_s;

   // Round-robin search starting one past the last winner, wrapping at NUM_UNITS.
   always_comb begin
      int  idx;
      logic found;
      grant_s   = '0;
      win_idx_s = '0;
      win_id_s  = '0;
      win_rd_s  = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_UNITS; k++) begin
         idx = int'(rr_ptr_r) + k;
         if (idx >= NUM_UNITS) begin
            idx = idx - NUM_UNITS;
         end else begin
            idx = idx;
         end
         if (!found && unit_done[idx]) begin
            found        = 1'b1;
            grant_s[idx] = 1'b1;
            win_idx_s    = IDX_W'(idx);
            win_id_s     = unit_id[idx*ID_W +: ID_W];
            win_rd_s     = unit_rd[idx*DATA_W +: DATA_W];
         end else begin
            found = found;
         end
      end
   end

   // Acks only go out when the slot can accept; reset suppresses them outright.
   assign unit_ack = rst ? '0 : (grant_s & {NUM_UNITS{load_s}});

   // Output stage and round-robin pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_id    <= '0;
         wb_rd    <= '0;
         wb_unit  <= '0;
         rr_ptr_r <= IDX_W'(NUM_UNITS - 1);
      end else if (load_s) begin
         if (any_grant_s) begin
            wb_valid <= 1'b1;
            wb_id    <= win_id_s;
            wb_rd    <= win_rd_s;
            wb_unit  <= win_idx_s;
            rr_ptr_r <= win_idx_s;
         end else begin
            wb_valid <= 1'b0;
         end
      end else begin
         wb_valid <= wb_valid;
      end
   end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed testbench for fp_wb_arbiter with hand-computed expectations.
module tb_fp_wb_arbiter;

   localparam int NU = 3;
   localparam int DW = 34;
   localparam int IW = 3;

   logic           clk;
   logic           rst;
   logic [NU-1:0]  unit_done;
   logic [NU*IW-1:0] unit_id;
   logic [NU*DW-1:0] unit_rd;
   logic [NU-1:0]  unit_ack;
   logic           wb_valid;
   logic           wb_ready;
   logic [IW-1:0]  wb_id;
   logic [DW-1:0]  wb_rd;
   logic [1:0]     wb_unit;

   int pass_cnt;
   int total_cnt;

   logic [IW-1:0] exp_id [NU];
   logic [DW-1:0] exp_rd [NU];

   fp_wb_arbiter #(.NUM_UNITS(NU), .DATA_W(DW), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .unit_done (unit_done),
      .unit_id   (unit_id),
      .unit_rd   (unit_rd),
      .unit_ack  (unit_ack),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_id     (wb_id),
      .wb_rd     (wb_rd),
      .wb_unit   (wb_unit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wb(input string tag, input int u);
      check({tag, "_valid"}, 64'(wb_valid), 64'd1);
      check({tag, "_unit"},  64'(wb_unit),  64'(u));
      check({tag, "_id"},    64'(wb_id),    64'(exp_id[u]));
      check({tag, "_rd"},    64'(wb_rd),    64'(exp_rd[u]));
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      exp_id[0] = 3'd3; exp_rd[0] = 34'h0_3F80_0000;
      exp_id[1] = 3'd5; exp_rd[1] = 34'h1_4049_0FDB;
      exp_id[2] = 3'd6; exp_rd[2] = 34'h2_C020_0000;
      unit_id  = {exp_id[2], exp_id[1], exp_id[0]};
      unit_rd  = {exp_rd[2], exp_rd[1], exp_rd[0]};
      rst       = 1'b1;
      unit_done = 3'b111;
      wb_ready  = 1'b1;

      // Reset held two cycles with every unit requesting
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_ack",   64'(unit_ack), 64'd0);
         check("rst_valid", 64'(wb_valid), 64'd0);
         check("rst_id",    64'(wb_id),    64'd0);
         check("rst_rd",    64'(wb_rd),    64'd0);
         check("rst_unit",  64'(wb_unit),  64'd0);
      end
      rst = 1'b0;
      #1;

      // Round-robin with all units requesting: 0,1,2,0 back to back
      for (int k = 0; k < 4; k++) begin
         check("rr_ack", 64'(unit_ack), 64'(3'b001 << (k % 3)));
         tick();
         check_wb("rr_wb", k % 3);
      end

      // Single request from unit 1
      unit_done = 3'b010;
      #1;
      check("single_ack", 64'(unit_ack), 64'b010);
      tick();
      check_wb("single_wb", 1);

      // Back-pressure for three cycles, unit 2 waiting
      wb_ready  = 1'b0;
      unit_done = 3'b100;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_ack", 64'(unit_ack), 64'd0);
         tick();
         check_wb("bp_hold", 1);
      end
      wb_ready = 1'b1;
      #1;
      check("bp_release_ack", 64'(unit_ack), 64'b100);
      tick();
      check_wb("bp_release_wb", 2);

      // Drain and refill in the same edge, pointer wraps 2 -> 0
      unit_done = 3'b001;
      #1;
      check("refill_ack", 64'(unit_ack), 64'b001);
      tick();
      check_wb("refill_wb", 0);

      // Idle drain: slot empties, data and pointer hold
      unit_done = 3'b000;
      #1;
      check("idle_ack", 64'(unit_ack), 64'd0);
      tick();
      check("idle_valid", 64'(wb_valid), 64'd0);
      check("idle_unit",  64'(wb_unit),  64'd0);
      unit_done = 3'b111;
      #1;
      check("idle_ptr_ack", 64'(unit_ack), 64'b010);

      // Empty slot loads even with wb_ready low
      wb_ready  = 1'b0;
      unit_done = 3'b101;
      #1;
      check("empty_load_ack", 64'(unit_ack), 64'b100);
      tick();
      check_wb("empty_load_wb", 2);
      check("full_bp_ack", 64'(unit_ack), 64'd0);

      // Reset mid-operation drops the held result
      rst       = 1'b1;
      unit_done = 3'b111;
      #1;
      check("midrst_ack", 64'(unit_ack), 64'd0);
      tick();
      check("midrst_valid", 64'(wb_valid), 64'd0);
      check("midrst_rd",    64'(wb_rd),    64'd0);
      rst      = 1'b0;
      wb_ready = 1'b1;
      #1;
      check("post_rst_ack", 64'(unit_ack), 64'b001);
      tick();
      check_wb("post_rst_wb", 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
